// File: rtl/bcd_seg_scan_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// driving a scanned 4-digit common-anode 7-segment display.
module bcd_seg_scan_ctrl #(
   parameter int REFRESH_DIV   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  bin_in,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd_out,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t        state_r, state_s;
   logic [7:0]    shift_r, shift_s;
   logic [11:0]   work_r, work_s, work_adj_s;
   logic [2:0]    count_r, count_s;
   logic [11:0]   bcd_r, bcd_s;
   logic [RW-1:0] refresh_r;
   logic [1:0]    digit_r;
   logic [3:0]    nib_s;
   logic          blank_s;

   function automatic logic [3:0] nib_adjust(input logic [3:0] n);
      return (n > 4'd4) ? (n + 4'd3) : n;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   assign work_adj_s = {nib_adjust(work_r[11:8]), nib_adjust(work_r[7:4]), nib_adjust(work_r[3:0])};

   // Conversion FSM next-state and datapath
   always_comb begin
      state_s = state_r;
      shift_s = shift_r;
      work_s  = work_r;
      count_s = count_r;
      bcd_s   = bcd_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               shift_s = bin_in;
               work_s  = 12'd0;
               count_s = 3'd0;
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            work_s  = {work_adj_s[10:0], shift_r[7]};
            shift_s = {shift_r[6:0], 1'b0};
            count_s = count_r + 3'd1;
            if (count_r == 3'd7) begin
               bcd_s   = work_s;
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Conversion state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         shift_r <= 8'd0;
         work_r  <= 12'd0;
         count_r <= 3'd0;
         bcd_r   <= 12'd0;
      end else begin
         state_r <= state_s;
         shift_r <= shift_s;
         work_r  <= work_s;
         count_r <= count_s;
         bcd_r   <= bcd_s;
      end
   end

   // Free-running scan: digit index advances on each refresh wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_r <= '0;
         digit_r   <= 2'd0;
      end else if (refresh_r == REFRESH_MAX) begin
         refresh_r <= '0;
         digit_r   <= digit_r + 2'd1;
      end else begin
         refresh_r <= refresh_r + {{(RW-1){1'b0}}, 1'b1};
         digit_r   <= digit_r;
      end
   end

   // Digit selection with optional leading-zero blanking
   always_comb begin
      nib_s   = 4'd0;
      blank_s = 1'b1;
      case (digit_r)
         2'd0: begin
            nib_s   = bcd_r[3:0];
            blank_s = 1'b0;
         end
         2'd1: begin
            nib_s   = bcd_r[7:4];
            blank_s = BLANK_LEADING && (bcd_r[11:8] == 4'd0) && (bcd_r[7:4] == 4'd0);
         end
         2'd2: begin
            nib_s   = bcd_r[11:8];
            blank_s = BLANK_LEADING && (bcd_r[11:8] == 4'd0);
         end
         default: begin
            nib_s   = 4'd0;
            blank_s = 1'b1;
         end
      endcase
   end

   assign an      = blank_s ? 4'b1111 : ~(4'b0001 << digit_r);
   assign seg     = blank_s ? 7'b1111111 : seg_decode(nib_s);
   assign dp      = 1'b1;
   assign busy    = (state_r == SHIFT);
   assign done    = (state_r == DONE);
   assign bcd_out = bcd_r;

endmodule

// File: tb/tb_bcd_seg_scan_ctrl.sv
// Self-checking bench: table vectors, held-start and reset sequences,
// random conversions against an arithmetic reference, and scan checks.
module tb_bcd_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  bin_in;
   logic        busy, done, dp, busy2, done2, dp2;
   logic [11:0] bcd_out, bcd_out2;
   logic [3:0]  an, an2;
   logic [6:0]  seg, seg2;

   int checks = 0;
   int errors = 0;
   int sc;
   logic [11:0] last_bcd;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs [0:6];

   bcd_seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy), .done(done),
      .bcd_out(bcd_out), .an(an), .seg(seg), .dp(dp));

   bcd_seg_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in), .busy(busy2), .done(done2),
      .bcd_out(bcd_out2), .an(an2), .seg(seg2), .dp(dp2));

   always #5 clk = ~clk;

   // Edges since the last reset; the scan position follows from it arithmetically
   always @(posedge clk) begin
      if (rst) sc <= 0;
      else     sc <= sc + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
   endfunction

   task automatic exp_disp(input logic [11:0] b, input int dg, input bit bl,
                           output logic [3:0] ea, output logic [6:0] es);
      int h, t, o, val;
      bit blank;
      logic [3:0] sel;
      h = int'(b[11:8]); t = int'(b[7:4]); o = int'(b[3:0]);
      if (dg == 3)      blank = 1'b1;
      else if (dg == 2) blank = bl && (h == 0);
      else if (dg == 1) blank = bl && (h == 0) && (t == 0);
      else              blank = 1'b0;
      val = (dg == 0) ? o : (dg == 1) ? t : h;
      sel = 4'(1 << dg);
      if (blank) begin
         ea = 4'b1111; es = 7'b1111111;
      end else begin
         ea = ~sel;
         es = (val <= 9) ? seg_tab[val] : 7'b1111111;
      end
   endtask

   task automatic check_scan(input logic [11:0] b);
      logic [3:0] ea;
      logic [6:0] es;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_disp(b, (sc / 4) % 4, 1'b1, ea, es);
         chk("an_blank", 32'(an), 32'(ea));
         chk("seg_blank", 32'(seg), 32'(es));
         exp_disp(b, (sc / 4) % 4, 1'b0, ea, es);
         chk("an_noblank", 32'(an2), 32'(ea));
         chk("seg_noblank", 32'(seg2), 32'(es));
      end
      chk("dp", 32'({dp, dp2}), 32'(2'b11));
   endtask

   task automatic convert(input logic [7:0] b, input logic [11:0] e);
      @(negedge clk);
      chk("idle_before_start", 32'(busy), 32'(0));
      start = 1'b1; bin_in = b;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         chk("busy_shift", 32'(busy), 32'(1));
         chk("done_shift", 32'(done), 32'(0));
         chk("bcd_hold", 32'(bcd_out), 32'(last_bcd));
         bin_in = 8'($urandom);
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'(1));
      chk("busy_done", 32'(busy), 32'(0));
      chk("bcd_result", 32'(bcd_out), 32'(e));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'(0));
      chk("busy_after", 32'(busy), 32'(0));
      last_bcd = e;
   endtask

   initial begin
      int hist [0:31];
      int v;
      vecs[0] = '{8'd255, 12'h255};
      vecs[1] = '{8'd0,   12'h000};
      vecs[2] = '{8'd9,   12'h009};
      vecs[3] = '{8'd10,  12'h010};
      vecs[4] = '{8'd99,  12'h099};
      vecs[5] = '{8'd100, 12'h100};
      vecs[6] = '{8'd128, 12'h128};

      rst = 1'b1; start = 1'b0; bin_in = 8'd0; last_bcd = 12'h000;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_bcd", 32'(bcd_out), 32'(0));
      chk("rst_an", 32'(an), 32'(4'b1110));
      chk("rst_seg", 32'(seg), 32'(7'b1000000));
      rst = 1'b0;

      for (int i = 0; i < 7; i++) convert(vecs[i].bin, vecs[i].exp);
      check_scan(12'h128);
      convert(8'd7, 12'h007);
      check_scan(12'h007);

      // start held high: a conversion every 10 cycles, bin_in sampled only at acceptance
      @(negedge clk);
      start = 1'b1; hist[0] = int'($urandom_range(255)); bin_in = 8'(hist[0]);
      for (int o = 0; o < 30; o++) begin
         @(negedge clk);
         chk("held_busy", 32'(busy), 32'((o % 10) < 8));
         chk("held_done", 32'(done), 32'((o % 10) == 8));
         if ((o % 10) == 8) chk("held_bcd", 32'(bcd_out), 32'(to_bcd(hist[o - 8])));
         hist[o + 1] = int'($urandom_range(255));
         bin_in = 8'(hist[o + 1]);
         if (o == 29) start = 1'b0;
      end
      last_bcd = to_bcd(hist[20]);

      // reset mid-conversion of 200
      @(negedge clk);
      start = 1'b1; bin_in = 8'd200;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_bcd", 32'(bcd_out), 32'(0));
      chk("abort_an", 32'(an), 32'(4'b1110));
      chk("abort_seg", 32'(seg), 32'(7'b1000000));
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'(0));
      end
      last_bcd = 12'h000;
      convert(8'd200, 12'h200);
      check_scan(12'h200);

      for (int i = 0; i < 20; i++) begin
         v = int'($urandom_range(255));
         convert(8'(v), to_bcd(v));
      end
      check_scan(last_bcd);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
